pll_reset_sequencer: RTL and testbench

- Parametrised PLL lock supervisor and staged reset generator for the ULX3S clock system.
- Runs on the free-running 25 MHz board clock `clkin`, so it operates before the PLL is locked.
- Drives the PLL reset input and waits for stable lock, then releases NUM_DOMAINS active-low domain resets in a fixed order.
- On lock loss it re-asserts all domain resets and counts the event; if the PLL fails to relock within a timeout, it pulses the PLL reset again.

---
 rtl/pll_reset_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable synchronised lock,
// then releases active-low domain resets in bit order; lock loss drops every domain at once.
module pll_reset_sequencer #(
    parameter int NUM_DOMAINS        = 3,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int RELOCK_TIMEOUT     = 65536,
    parameter int PLLRST_PULSE       = 8,
    parameter int CNT_W              = 8
) (
    input  logic                   clkin,
    input  logic                   resetn,
    input  logic                   locked_async,
    input  logic                   force_reset,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_resetn,
    output logic                   all_ready,
    output logic [CNT_W-1:0]       loss_count,
    output logic [2:0]             state
);

    localparam int PW = $clog2(PLLRST_PULSE + 1);
    localparam int TW = $clog2(RELOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP_CYCLES + 1);

    localparam logic [PW-1:0] PULSE_LAST   = PW'(PLLRST_PULSE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(RELOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STABLE_DONE  = SW'(LOCK_STABLE_CYCLES);
    localparam logic [GW-1:0] GAP_LAST     = GW'(STAGE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic                   locked_s;
    logic [PW-1:0]          pulse_cnt, pulse_cnt_d;
    logic [TW-1:0]          wait_cnt, wait_cnt_d;
    logic [SW-1:0]          stable_cnt, stable_cnt_d;
    logic [GW-1:0]          gap_cnt, gap_cnt_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] domain_q, domain_d;
    logic                   ready_q, ready_d;
    logic [CNT_W-1:0]       loss_q, loss_d;

    assign locked_s = sync_q[1];

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_PLL_RST;
            sync_q     <= '0;
            pulse_cnt  <= '0;
            wait_cnt   <= '0;
            stable_cnt <= '0;
            gap_cnt    <= '0;
            pll_rst_q  <= 1'b1;
            domain_q   <= '0;
            ready_q    <= 1'b0;
            loss_q     <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], locked_async};
            pulse_cnt  <= pulse_cnt_d;
            wait_cnt   <= wait_cnt_d;
            stable_cnt <= stable_cnt_d;
            gap_cnt    <= gap_cnt_d;
            pll_rst_q  <= pll_rst_d;
            domain_q   <= domain_d;
            ready_q    <= ready_d;
            loss_q     <= loss_d;
        end
    end

    // Counters default to zero, so any state change clears them.
    always_comb begin
        state_d      = state_q;
        pulse_cnt_d  = '0;
        wait_cnt_d   = '0;
        stable_cnt_d = '0;
        gap_cnt_d    = '0;
        pll_rst_d    = pll_rst_q;
        domain_d     = domain_q;
        ready_d      = ready_q;
        loss_d       = loss_q;

        case (state_q)
            S_PLL_RST: begin
                pll_rst_d = 1'b1;
                domain_d  = '0;
                ready_d   = 1'b0;
                if (pulse_cnt == PULSE_LAST) begin
                    state_d   = S_WAIT_LOCK;
                    pll_rst_d = 1'b0;
                end else begin
                    pulse_cnt_d = pulse_cnt + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d      = S_STABLE;
                    stable_cnt_d = SW'(1);
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    state_d   = S_PLL_RST;
                    pll_rst_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (stable_cnt == STABLE_DONE) begin
                    state_d  = S_RELEASE;
                    domain_d = NUM_DOMAINS'(1);
                end else begin
                    stable_cnt_d = stable_cnt + 1'b1;
                end
            end
            S_RELEASE, S_RUN: begin
                if (!locked_s) begin
                    state_d  = S_WAIT_LOCK;
                    domain_d = '0;
                    ready_d  = 1'b0;
                    loss_d   = (loss_q == '1) ? loss_q : loss_q + 1'b1;
                end else if (state_q == S_RELEASE) begin
                    if (&domain_q) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end else if (gap_cnt == GAP_LAST) begin
                        // Shift in a 1 so bits release strictly in order.
                        domain_d = NUM_DOMAINS'({domain_q, 1'b1});
                    end else begin
                        gap_cnt_d = gap_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_PLL_RST;
                pll_rst_d = 1'b1;
                domain_d  = '0;
                ready_d   = 1'b0;
            end
        endcase

        // A restart request overrides everything, including a simultaneous lock loss.
        if (force_reset && state_q != S_PLL_RST) begin
            state_d      = S_PLL_RST;
            pll_rst_d    = 1'b1;
            domain_d     = '0;
            ready_d      = 1'b0;
            loss_d       = loss_q;
            pulse_cnt_d  = '0;
            wait_cnt_d   = '0;
            stable_cnt_d = '0;
            gap_cnt_d    = '0;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign domain_resetn = domain_q;
    assign all_ready     = ready_q;
    assign loss_count    = loss_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: drivers queue timed expectations of the packed output word,
// a negedge monitor pops and compares them as the design reaches each cycle.
module tb_pll_reset_sequencer;

    logic       clkin = 1'b0;
    logic       resetn;
    logic       locked_async;
    logic       force_reset;
    logic       pll_rst;
    logic [2:0] domain_resetn;
    logic       all_ready;
    logic [1:0] loss_count;
    logic [2:0] state;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    logic [9:0] exp_q[$];
    int         exp_cyc_q[$];
    string      tag_q[$];

    pll_reset_sequencer #(
        .NUM_DOMAINS(3),
        .LOCK_STABLE_CYCLES(4),
        .STAGE_GAP_CYCLES(2),
        .RELOCK_TIMEOUT(20),
        .PLLRST_PULSE(3),
        .CNT_W(2)
    ) dut (
        .clkin(clkin),
        .resetn(resetn),
        .locked_async(locked_async),
        .force_reset(force_reset),
        .pll_rst(pll_rst),
        .domain_resetn(domain_resetn),
        .all_ready(all_ready),
        .loss_count(loss_count),
        .state(state)
    );

    // Clock and cycle index
    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    function automatic logic [9:0] obs(input logic [2:0] st, input logic pr,
                                       input logic [2:0] dom, input logic rdy,
                                       input logic [1:0] loss);
        return {st, pr, dom, rdy, loss};
    endfunction

    function automatic logic [9:0] observed();
        return {state, pll_rst, domain_resetn, all_ready, loss_count};
    endfunction

    task automatic check_obs(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got st=%0d pll_rst=%b dom=%b rdy=%b loss=%0d, expected st=%0d pll_rst=%b dom=%b rdy=%b loss=%0d",
                     tag, cyc, got[9:7], got[6], got[5:3], got[2], got[1:0],
                     exp[9:7], exp[6], exp[5:3], exp[2], exp[1:0]);
        end
    endtask

    task automatic expect_at(input int at, input string tag, input logic [9:0] v);
        exp_cyc_q.push_back(at);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    // Scoreboard monitor
    always @(negedge clkin) begin
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            void'(exp_cyc_q.pop_front());
            check_obs(tag_q.pop_front(), observed(), exp_q.pop_front());
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    // Called right after raising locked_async; next edge is the first sampling edge E.
    task automatic run_release(input logic [1:0] l);
        int c;
        c = cyc;
        expect_at(c + 2,  "rel_wait",   obs(3'd1, 1'b0, 3'b000, 1'b0, l));
        expect_at(c + 3,  "rel_stable", obs(3'd2, 1'b0, 3'b000, 1'b0, l));
        expect_at(c + 6,  "rel_st_end", obs(3'd2, 1'b0, 3'b000, 1'b0, l));
        expect_at(c + 7,  "rel_d0",     obs(3'd3, 1'b0, 3'b001, 1'b0, l));
        expect_at(c + 8,  "rel_d0_hold", obs(3'd3, 1'b0, 3'b001, 1'b0, l));
        expect_at(c + 9,  "rel_d1",     obs(3'd3, 1'b0, 3'b011, 1'b0, l));
        expect_at(c + 10, "rel_d1_hold", obs(3'd3, 1'b0, 3'b011, 1'b0, l));
        expect_at(c + 11, "rel_d2",     obs(3'd3, 1'b0, 3'b111, 1'b0, l));
        expect_at(c + 12, "rel_run",    obs(3'd4, 1'b0, 3'b111, 1'b1, l));
        wait_cycles(12);
    endtask

    task automatic lose_lock(input logic [1:0] prev, input logic [1:0] nxt);
        int c;
        locked_async = 1'b0;
        c = cyc;
        expect_at(c + 2, "loss_hold", obs(3'd4, 1'b0, 3'b111, 1'b1, prev));
        expect_at(c + 3, "loss_drop", obs(3'd1, 1'b0, 3'b000, 1'b0, nxt));
        wait_cycles(3);
    endtask

    task automatic relock(input logic [1:0] l);
        wait_cycles($urandom_range(0, 10));
        locked_async = 1'b1;
        run_release(l);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        resetn       = 1'b0;
        locked_async = 1'b0;
        force_reset  = 1'b0;
        #12;
        check_obs("in_reset", observed(), obs(3'd0, 1'b1, 3'b000, 1'b0, 2'd0));

        // Unlocked PLL: 3-cycle pulse, 20 cycles waiting, pulse again
        @(negedge clkin);
        resetn = 1'b1;
        c = cyc;
        expect_at(c + 2,  "pulse1",      obs(3'd0, 1'b1, 3'b000, 1'b0, 2'd0));
        expect_at(c + 3,  "pulse1_end",  obs(3'd1, 1'b0, 3'b000, 1'b0, 2'd0));
        expect_at(c + 22, "timeout_pre", obs(3'd1, 1'b0, 3'b000, 1'b0, 2'd0));
        expect_at(c + 23, "pulse2",      obs(3'd0, 1'b1, 3'b000, 1'b0, 2'd0));
        expect_at(c + 25, "pulse2_hold", obs(3'd0, 1'b1, 3'b000, 1'b0, 2'd0));
        expect_at(c + 26, "pulse2_end",  obs(3'd1, 1'b0, 3'b000, 1'b0, 2'd0));
        wait_cycles(26);

        relock(2'd0);
        lose_lock(2'd0, 2'd1);
        relock(2'd1);
        lose_lock(2'd1, 2'd2);

        // One-cycle glitch while in STABLE
        wait_cycles($urandom_range(0, 10));
        locked_async = 1'b1;
        c = cyc;
        expect_at(c + 3, "glitch_stable", obs(3'd2, 1'b0, 3'b000, 1'b0, 2'd2));
        wait_cycles(3);
        locked_async = 1'b0;
        wait_cycles(1);
        locked_async = 1'b1;
        expect_at(cyc + 1, "glitch_hold", obs(3'd2, 1'b0, 3'b000, 1'b0, 2'd2));
        run_release(2'd2);

        // force_reset coincident with synchronised lock loss in RUN
        locked_async = 1'b0;
        c = cyc;
        expect_at(c + 2, "force_pre", obs(3'd4, 1'b0, 3'b111, 1'b1, 2'd2));
        wait_cycles(2);
        force_reset = 1'b1;
        expect_at(c + 3, "force_rst",    obs(3'd0, 1'b1, 3'b000, 1'b0, 2'd2));
        wait_cycles(1);
        expect_at(c + 4, "force_ign",    obs(3'd0, 1'b1, 3'b000, 1'b0, 2'd2));
        expect_at(c + 5, "force_pulse3", obs(3'd0, 1'b1, 3'b000, 1'b0, 2'd2));
        expect_at(c + 6, "force_done",   obs(3'd1, 1'b0, 3'b000, 1'b0, 2'd2));
        wait_cycles(1);
        force_reset = 1'b0;
        wait_cycles(2);

        // Saturation of the 2-bit loss counter
        relock(2'd2);
        lose_lock(2'd2, 2'd3);
        relock(2'd3);
        lose_lock(2'd3, 2'd3);
        relock(2'd3);
        lose_lock(2'd3, 2'd3);

        // Asynchronous reset in the middle of RELEASE
        locked_async = 1'b1;
        c = cyc;
        expect_at(c + 9, "mid_release", obs(3'd3, 1'b0, 3'b011, 1'b0, 2'd3));
        wait_cycles(9);
        @(negedge clkin);
        #2;
        resetn = 1'b0;
        #1;
        check_obs("async_reset", observed(), obs(3'd0, 1'b1, 3'b000, 1'b0, 2'd0));
        locked_async = 1'b0;
        @(negedge clkin);
        resetn = 1'b1;
        c = cyc;
        expect_at(c + 2, "rst_pulse", obs(3'd0, 1'b1, 3'b000, 1'b0, 2'd0));
        expect_at(c + 3, "rst_wait",  obs(3'd1, 1'b0, 3'b000, 1'b0, 2'd0));
        wait_cycles(4);
        @(negedge clkin);
        #1;
        check_obs("drain", 10'(exp_q.size()), 10'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
